// File: rtl/rr_mux_nto1.sv
// N-channel valid/ready multiplexer with round-robin or fixed-select
// arbitration feeding a one-entry registered output stage.
module rr_mux_nto1 #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_ch,
    input  logic                         out_ready
);

    localparam int PADW = 2 ** SEL_WIDTH;

    logic [SEL_WIDTH-1:0]  r_ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_WIDTH-1:0]  r_out_ch;

    logic                  w_load;
    logic                  w_rr_hit;
    logic                  w_fix_hit;
    logic                  w_gnt_hit;
    logic                  w_xfer;
    logic [SEL_WIDTH-1:0]  w_rr_idx;
    logic [SEL_WIDTH-1:0]  w_gnt;
    logic [NUM_CH-1:0]     w_above;
    logic [NUM_CH-1:0]     w_masked;
    logic [PADW-1:0]       w_vpad;
    logic [DATA_WIDTH-1:0] w_sel_data;

    assign w_load = !r_out_valid | out_ready;

    always_comb begin
        w_above = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_above[i] = (SEL_WIDTH'(i) > r_ptr);
        end
    end

    assign w_masked = in_valid & w_above;
    assign w_rr_hit = |in_valid;

    // Lowest requester above the pointer wins, else wrap to lowest overall.
    always_comb begin
        w_rr_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_valid[i]) w_rr_idx = SEL_WIDTH'(i);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_masked[i]) w_rr_idx = SEL_WIDTH'(i);
        end
    end

    // Zero padding makes any sel >= NUM_CH see an idle channel.
    assign w_vpad    = PADW'(in_valid);
    assign w_fix_hit = w_vpad[sel];

    assign w_gnt_hit = mode ? w_fix_hit : w_rr_hit;
    assign w_gnt     = mode ? sel : w_rr_idx;
    assign w_xfer    = w_gnt_hit & w_load;

    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt == SEL_WIDTH'(i)) begin
                in_ready[i] = w_xfer & reset;
                w_sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= SEL_WIDTH'(NUM_CH - 1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load) begin
            if (w_gnt_hit) begin
                r_ptr       <= w_gnt;
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_gnt;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_mux_nto1.sv
// Bench for rr_mux_nto1: directed vector table, corner sequences,
// NUM_CH=3 build checks and randomized traffic against a model.
module tb_rr_mux_nto1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mode = 1'b0;
    logic [1:0]   sel = '0;
    logic [3:0]   in_valid = '0;
    logic [127:0] in_data = '0;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_ready = 1'b0;

    logic         mode3 = 1'b1;
    logic [1:0]   sel3 = '0;
    logic [2:0]   vld3 = '0;
    logic [95:0]  data3 = '0;
    logic [2:0]   rdy3;
    logic         ov3;
    logic [31:0]  od3;
    logic [1:0]   och3;
    logic         ordy3 = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_mux_nto1 #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2)) u_dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    rr_mux_nto1 #(.DATA_WIDTH(32), .NUM_CH(3), .SEL_WIDTH(2)) u_dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
        .in_valid(vld3), .in_data(data3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_ch(och3),
        .out_ready(ordy3)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_v;
        logic [1:0]  e_ch;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl[17];

    int          mptr;
    bit          mv;
    logic [31:0] md;
    int          mc;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v,
                           input logic [1:0] ch, input logic [31:0] d);
        chk({nm, "_valid"}, 64'(out_valid), 64'(v));
        chk({nm, "_ch"}, 64'(out_ch), 64'(ch));
        chk({nm, "_data"}, 64'(out_data), 64'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[1]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[2]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[3]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[4]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[5]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[6]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[7]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
        tbl[8]  = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[9]  = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[10] = '{1'b1, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
        tbl[11] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
        tbl[12] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3};
        tbl[13] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3};
        tbl[14] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3};
        tbl[15] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
        tbl[16] = '{1'b1, 2'd3, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA0};

        // Reset held with all channels requesting
        in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #3;
        chk("rst_ready", 64'(in_ready), 64'h0);
        chk_out("rst", 1'b0, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        foreach (tbl[i]) begin
            mode      = tbl[i].mode;
            sel       = tbl[i].sel;
            in_valid  = tbl[i].vld;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready),
                64'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk_out($sformatf("tbl%0d", i), tbl[i].e_v, tbl[i].e_ch,
                    tbl[i].e_d);
        end

        // Fixed select streaming one channel
        in_data[64 +: 32] = 32'hDEADBEEF;
        mode      = 1'b1;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fix_ready", 64'(in_ready), 64'b0100);
            @(posedge clk);
            #1;
            chk_out("fix", 1'b1, 2'd2, 32'hDEADBEEF);
        end
        in_valid = 4'b1011;
        @(posedge clk);
        #1;
        chk_out("fix_drop", 1'b0, 2'd2, 32'hDEADBEEF);

        // Asynchronous reset while holding valid output
        mode     = 1'b0;
        in_valid = 4'b1111;
        @(posedge clk);
        #1;
        chk_out("pre_rst", 1'b1, 2'd3, 32'hA3);
        #2 reset = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 32'h0);
        chk("async_rst_ready", 64'(in_ready), 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(in_ready), 64'b0001);
        @(posedge clk);
        #1;
        chk_out("post_rst", 1'b1, 2'd0, 32'hA0);

        // Three-channel build: in-range and out-of-range select
        in_valid   = 4'b0000;
        data3      = {32'h32, 32'h31, 32'h30};
        sel3       = 2'd2;
        vld3       = 3'b000;
        @(negedge clk);
        chk("n3_idle_ready", 64'(rdy3), 64'h0);
        @(posedge clk);
        #1;
        chk("n3_idle_valid", 64'(ov3), 64'h0);
        vld3 = 3'b100;
        @(negedge clk);
        chk("n3_ready", 64'(rdy3), 64'b100);
        @(posedge clk);
        #1;
        chk("n3_valid", 64'(ov3), 64'h1);
        chk("n3_ch", 64'(och3), 64'h2);
        chk("n3_data", 64'(od3), 64'h32);
        sel3 = 2'd3;
        vld3 = 3'b111;
        @(negedge clk);
        chk("n3_oor_ready", 64'(rdy3), 64'h0);
        @(posedge clk);
        #1;
        chk("n3_oor_valid", 64'(ov3), 64'h0);

        // Randomized traffic against the reference model
        reset = 1'b0;
        #2 reset = 1'b1;
        mptr = 3;
        mv   = 1'b0;
        md   = '0;
        mc   = 0;
        for (int n = 0; n < 400; n++) begin
            int   g;
            bit   load;
            logic [3:0] erdy;
            mode      = ($urandom_range(0, 3) == 0);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
            @(negedge clk);
            g = -1;
            if (!mode) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (mptr + k) % 4;
                    if (g < 0 && in_valid[c]) g = c;
                end
            end else if (in_valid[sel]) begin
                g = int'(sel);
            end
            load = !mv || out_ready;
            erdy = (g >= 0 && load) ? (4'b0001 << g) : 4'b0000;
            chk("rnd_ready", 64'(in_ready), 64'(erdy));
            @(posedge clk);
            if (load) begin
                if (g >= 0) begin
                    mv   = 1'b1;
                    md   = in_data[g*32 +: 32];
                    mc   = g;
                    mptr = g;
                end else begin
                    mv = 1'b0;
                end
            end
            #1;
            chk_out("rnd", mv, 2'(mc), md);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
